uart_ip_param: RTL and testbench

Parametrised successor to the fixed 8N1 UART core. It is a full-duplex UART with compile-time data width, parity and stop-bit count, and a run-time baud divisor. The receiver adds glitch rejection plus per-frame parity and framing error flags. It sits between the bus-side UART register block and the chip pins, with the same start/done TX handshake and data-valid RX strobe as the existing core.

---
 rtl/uart_ip_param.sv | 223 ++++++++++++++++++++++
 tb/tb_uart_ip_param.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ip_param.sv
// ============================================================================
// Module  : uart_ip_param
// Brief   : Full-duplex UART, compile-time framing, run-time baud divisor,
//           glitch-rejecting receiver with parity/framing error flags.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_ip_param #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int DIV_W      = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DIV_W-1:0]     baud_div,
    output logic                 uart_TXD,
    input  logic                 uart_RXD,
    input  logic                 TX_start,
    input  logic [DATA_BITS-1:0] TX_data,
    output logic                 TX_busy,
    output logic                 TX_done,
    output logic [DATA_BITS-1:0] RX_data,
    output logic                 RX_dv,
    output logic                 RX_parity_err,
    output logic                 RX_frame_err
);

    localparam logic       c_PAR_EN    = (PARITY_EN != 0);
    localparam logic       c_PAR_ODD   = (PARITY_ODD != 0);
    localparam logic [2:0] c_LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] c_LAST_STOP = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ---------------------------------------------------------------- TX
    state_t                 r_tx_state, w_tx_next;
    logic [DIV_W-1:0]       r_tx_div, r_tx_cnt;
    logic [DATA_BITS-1:0]   r_tx_shift;
    logic [2:0]             r_tx_idx;
    logic                   r_tx_par, r_txd, r_tx_done;
    logic                   w_tx_bit_end;

    always_comb begin
        w_tx_next    = r_tx_state;
        w_tx_bit_end = (r_tx_cnt == r_tx_div);
        case (r_tx_state)
            S_IDLE:   if (TX_start) w_tx_next = S_START;
            S_START:  if (w_tx_bit_end) w_tx_next = S_DATA;
            S_DATA:   if (w_tx_bit_end && (r_tx_idx == c_LAST_DATA))
                          w_tx_next = c_PAR_EN ? S_PARITY : S_STOP;
            S_PARITY: if (w_tx_bit_end) w_tx_next = S_STOP;
            S_STOP:   if (w_tx_bit_end && (r_tx_idx == c_LAST_STOP))
                          w_tx_next = S_IDLE;
            default:  w_tx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) r_tx_state <= S_IDLE;
        else        r_tx_state <= w_tx_next;
    end

    // Line level is registered and set up for the state being entered.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_txd      <= 1'b1;
            r_tx_done  <= 1'b0;
            r_tx_cnt   <= '0;
            r_tx_div   <= '0;
            r_tx_shift <= '0;
            r_tx_idx   <= '0;
            r_tx_par   <= 1'b0;
        end else begin
            r_tx_done <= 1'b0;
            if (r_tx_state == S_IDLE) begin
                if (TX_start) begin
                    r_tx_shift <= TX_data;
                    r_tx_div   <= baud_div;
                    r_tx_par   <= (^TX_data) ^ c_PAR_ODD;
                    r_tx_cnt   <= '0;
                    r_tx_idx   <= '0;
                    r_txd      <= 1'b0;
                end
            end else if (!w_tx_bit_end) begin
                r_tx_cnt <= r_tx_cnt + 1'b1;
            end else begin
                r_tx_cnt <= '0;
                case (w_tx_next)
                    S_DATA: begin
                        if (r_tx_state == S_DATA) begin
                            r_tx_shift <= r_tx_shift >> 1;
                            r_txd      <= r_tx_shift[1];
                            r_tx_idx   <= r_tx_idx + 3'd1;
                        end else begin
                            r_txd <= r_tx_shift[0];
                        end
                    end
                    S_PARITY: r_txd <= r_tx_par;
                    S_STOP: begin
                        r_txd    <= 1'b1;
                        r_tx_idx <= (r_tx_state == S_STOP) ? r_tx_idx + 3'd1 : 3'd0;
                    end
                    S_IDLE: begin
                        r_txd     <= 1'b1;
                        r_tx_done <= 1'b1;
                    end
                    default: r_txd <= 1'b1;
                endcase
            end
        end
    end

    assign uart_TXD = r_txd;
    assign TX_busy  = (r_tx_state != S_IDLE);
    assign TX_done  = r_tx_done;

    // ---------------------------------------------------------------- RX
    state_t                 r_rx_state, w_rx_next;
    logic                   r_rx_s1, r_rx_s2, r_rx_hist;
    logic [DIV_W-1:0]       r_rx_div, r_rx_cnt;
    logic [DATA_BITS-1:0]   r_rx_shift, r_rx_data;
    logic [2:0]             r_rx_idx;
    logic                   r_rx_par, r_rx_perr;
    logic                   r_rx_dv, r_rx_perr_o, r_rx_ferr_o;
    logic                   w_rx_fall, w_rx_tick;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_hist <= 1'b1;
        end else begin
            r_rx_s1   <= uart_RXD;
            r_rx_s2   <= r_rx_s1;
            r_rx_hist <= r_rx_s2;
        end
    end

    // Start bit is probed half a bit in; every later sample is one full bit on.
    always_comb begin
        w_rx_next = r_rx_state;
        w_rx_fall = r_rx_hist & ~r_rx_s2;
        w_rx_tick = (r_rx_state == S_START) ? (r_rx_cnt == (r_rx_div >> 1))
                                            : (r_rx_cnt == r_rx_div);
        case (r_rx_state)
            S_IDLE:   if (w_rx_fall) w_rx_next = S_START;
            S_START:  if (w_rx_tick) w_rx_next = r_rx_s2 ? S_IDLE : S_DATA;
            S_DATA:   if (w_rx_tick && (r_rx_idx == c_LAST_DATA))
                          w_rx_next = c_PAR_EN ? S_PARITY : S_STOP;
            S_PARITY: if (w_rx_tick) w_rx_next = S_STOP;
            S_STOP:   if (w_rx_tick) w_rx_next = S_IDLE;
            default:  w_rx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) r_rx_state <= S_IDLE;
        else        r_rx_state <= w_rx_next;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rx_div    <= '0;
            r_rx_cnt    <= '0;
            r_rx_shift  <= '0;
            r_rx_data   <= '0;
            r_rx_idx    <= '0;
            r_rx_par    <= 1'b0;
            r_rx_perr   <= 1'b0;
            r_rx_dv     <= 1'b0;
            r_rx_perr_o <= 1'b0;
            r_rx_ferr_o <= 1'b0;
        end else begin
            r_rx_dv <= 1'b0;
            if (r_rx_state == S_IDLE) begin
                if (w_rx_fall) begin
                    r_rx_div  <= baud_div;
                    r_rx_cnt  <= '0;
                    r_rx_idx  <= '0;
                    r_rx_par  <= 1'b0;
                    r_rx_perr <= 1'b0;
                end
            end else if (!w_rx_tick) begin
                r_rx_cnt <= r_rx_cnt + 1'b1;
            end else begin
                r_rx_cnt <= '0;
                case (r_rx_state)
                    S_DATA: begin
                        r_rx_shift <= {r_rx_s2, r_rx_shift[DATA_BITS-1:1]};
                        r_rx_par   <= r_rx_par ^ r_rx_s2;
                        r_rx_idx   <= r_rx_idx + 3'd1;
                    end
                    S_PARITY: r_rx_perr <= r_rx_par ^ r_rx_s2 ^ c_PAR_ODD;
                    S_STOP: begin
                        r_rx_dv     <= 1'b1;
                        r_rx_data   <= r_rx_shift;
                        r_rx_ferr_o <= ~r_rx_s2;
                        r_rx_perr_o <= c_PAR_EN & r_rx_perr;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign RX_data       = r_rx_data;
    assign RX_dv         = r_rx_dv;
    assign RX_parity_err = r_rx_perr_o;
    assign RX_frame_err  = r_rx_ferr_o;

endmodule

`default_nettype wire

// File: tb/tb_uart_ip_param.sv
// ============================================================================
// Module  : tb_uart_ip_param
// Brief   : Self-checking bench, behavioural frame model, two parameter sets.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_ip_param;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] a_div, b_div;
    logic        a_start, b_start;
    logic [7:0]  a_data;
    logic [6:0]  b_data;
    logic        a_drv, b_drv;
    logic        a_txd, b_txd, a_rxd, b_rxd;
    logic        a_busy, a_done, a_dv, a_perr, a_ferr;
    logic        b_busy, b_done, b_dv, b_perr, b_ferr;
    logic [7:0]  a_rx_data;
    logic [6:0]  b_rx_data;

    int n_vec = 0;
    int n_err = 0;
    int a_done_cnt = 0;
    logic [9:0] qa[$];
    logic [9:0] qb[$];

    always #5 clock = ~clock;

    // Loopback is always present; the bench pulls the line low to inject frames.
    assign a_rxd = a_txd & a_drv;
    assign b_rxd = b_txd & b_drv;

    uart_ip_param u_dut_a (
        .clock(clock), .reset(reset), .baud_div(a_div),
        .uart_TXD(a_txd), .uart_RXD(a_rxd),
        .TX_start(a_start), .TX_data(a_data), .TX_busy(a_busy), .TX_done(a_done),
        .RX_data(a_rx_data), .RX_dv(a_dv),
        .RX_parity_err(a_perr), .RX_frame_err(a_ferr)
    );

    uart_ip_param #(.DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2), .DIV_W(16)) u_dut_b (
        .clock(clock), .reset(reset), .baud_div(b_div),
        .uart_TXD(b_txd), .uart_RXD(b_rxd),
        .TX_start(b_start), .TX_data(b_data), .TX_busy(b_busy), .TX_done(b_done),
        .RX_data(b_rx_data), .RX_dv(b_dv),
        .RX_parity_err(b_perr), .RX_frame_err(b_ferr)
    );

    always @(negedge clock) begin
        if (a_dv === 1'b1) qa.push_back({a_perr, a_ferr, a_rx_data});
        if (b_dv === 1'b1) qb.push_back({b_perr, b_ferr, 1'b0, b_rx_data});
        if (a_done === 1'b1) a_done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ones(input logic [7:0] d, input int nb);
        int n = 0;
        for (int i = 0; i < nb; i++) n += int'(d[i]);
        return n;
    endfunction

    // Line level of bit 'idx' of a parity-enabled frame.
    function automatic logic model_bit(input logic [7:0] d, input int nb, input int podd, input int idx);
        if (idx == 0)      return 1'b0;
        if (idx <= nb)     return d[idx-1];
        if (idx == nb + 1) return ((ones(d, nb) + podd) % 2) != 0;
        return 1'b1;
    endfunction

    // Starts a frame in the current cycle and checks every cycle through TX_done.
    // Returns at the falling edge of the done cycle so a chained call starts with no gap.
    task automatic tx_frame(input bit sel, input logic [7:0] d, input int div, input int poke);
        int nb     = sel ? 7 : 8;
        int nstop  = sel ? 2 : 1;
        int podd   = sel ? 1 : 0;
        int bitlen = div + 1;
        int flen   = (2 + nb + nstop) * bitlen;
        logic txd, busy, done;
        if (sel) begin b_start = 1'b1; b_data = d[6:0]; b_div = 16'(div); end
        else     begin a_start = 1'b1; a_data = d;      a_div = 16'(div); end
        for (int k = 1; k <= flen + 1; k++) begin
            @(posedge clock); #1;
            if (k == 1) begin a_start = 1'b0; b_start = 1'b0; end
            if (poke != 0 && k == poke) begin
                if (sel) begin b_start = 1'b1; b_data = ~d[6:0]; b_div = 16'(div + 4); end
                else     begin a_start = 1'b1; a_data = ~d;      a_div = 16'(div + 4); end
            end
            if (poke != 0 && k == poke + 1) begin a_start = 1'b0; b_start = 1'b0; end
            @(negedge clock);
            txd  = sel ? b_txd  : a_txd;
            busy = sel ? b_busy : a_busy;
            done = sel ? b_done : a_done;
            if (k <= flen) begin
                chk("tx_line", {31'd0, txd}, {31'd0, model_bit(d, nb, podd, (k-1)/bitlen)});
                chk("tx_busy", {31'd0, busy}, 32'd1);
                chk("tx_done_early", {31'd0, done}, 32'd0);
            end else begin
                chk("tx_done_pulse", {31'd0, done}, 32'd1);
                chk("tx_busy_end", {31'd0, busy}, 32'd0);
                chk("tx_line_idle", {31'd0, txd}, 32'd1);
            end
        end
    endtask

    task automatic rx_drive(input logic [7:0] d, input logic pbit, input logic sbit, input int div);
        a_div = 16'(div);
        for (int i = 0; i < 11; i++) begin
            if (i == 0)       a_drv = 1'b0;
            else if (i <= 8)  a_drv = d[i-1];
            else if (i == 9)  a_drv = pbit;
            else              a_drv = sbit;
            repeat (div + 1) @(posedge clock);
            #1;
        end
        a_drv = 1'b1;
        repeat (3 * (div + 1)) @(posedge clock);
        #1;
    endtask

    task automatic rx_expect(input bit sel, input string tag, input logic [7:0] d,
                             input logic perr, input logic ferr);
        logic [9:0] e;
        if ((sel ? qb.size() : qa.size()) == 0) begin
            chk({tag, "_dv_seen"}, 32'd0, 32'd1);
        end else begin
            e = sel ? qb.pop_front() : qa.pop_front();
            chk({tag, "_data"}, {24'd0, e[7:0]}, {24'd0, d});
            chk({tag, "_perr"}, {31'd0, e[9]}, {31'd0, perr});
            chk({tag, "_ferr"}, {31'd0, e[8]}, {31'd0, ferr});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d, exp_q[$];
        logic       pb, sb;
        int         dv, dc;

        reset = 1'b0; a_start = 1'b0; b_start = 1'b0; a_data = '0; b_data = '0;
        a_div = 16'd9; b_div = 16'd3; a_drv = 1'b1; b_drv = 1'b1;
        repeat (4) @(posedge clock);
        @(negedge clock);
        chk("rst_txd_a", {31'd0, a_txd}, 32'd1);
        chk("rst_txd_b", {31'd0, b_txd}, 32'd1);
        chk("rst_busy", {30'd0, a_busy, b_busy}, 32'd0);
        chk("rst_done", {30'd0, a_done, b_done}, 32'd0);
        chk("rst_dv", {30'd0, a_dv, b_dv}, 32'd0);
        chk("rst_rx_data", {17'd0, b_rx_data, a_rx_data}, 32'd0);
        chk("rst_errs", {28'd0, a_perr, a_ferr, b_perr, b_ferr}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        idle(3);

        // 0xA5 at baud_div=9, checked bit by bit; loopback receives it.
        tx_frame(1'b0, 8'hA5, 9, 0);
        idle(20);
        rx_expect(1'b0, "lb_a5", 8'hA5, 1'b0, 1'b0);

        // Back-to-back frames, second started in the TX_done cycle.
        tx_frame(1'b0, 8'h3C, 9, 0);
        tx_frame(1'b0, 8'hC3, 9, 0);
        idle(20);
        rx_expect(1'b0, "b2b_1", 8'h3C, 1'b0, 1'b0);
        rx_expect(1'b0, "b2b_2", 8'hC3, 1'b0, 1'b0);
        chk("b2b_extra", qa.size(), 32'd0);

        // Injected parity and framing errors.
        rx_drive(8'h01, 1'b0, 1'b1, 9);
        rx_expect(1'b0, "perr", 8'h01, 1'b1, 1'b0);
        rx_drive(8'h01, 1'b1, 1'b0, 9);
        rx_expect(1'b0, "ferr", 8'h01, 1'b0, 1'b1);

        // Glitch then break.
        a_div = 16'd9;
        a_drv = 1'b0; idle(3); a_drv = 1'b1;
        idle(150);
        chk("glitch_no_dv", qa.size(), 32'd0);
        a_drv = 1'b0; idle(200);
        chk("break_one_dv", qa.size(), 32'd1);
        a_drv = 1'b1; idle(60);
        chk("break_no_retrigger", qa.size(), 32'd1);
        rx_expect(1'b0, "break", 8'h00, 1'b0, 1'b1);

        // TX_start and baud_div poked mid-frame must not disturb the frame.
        tx_frame(1'b0, 8'h96, 9, 35);
        idle(20);
        rx_expect(1'b0, "poke", 8'h96, 1'b0, 1'b0);
        chk("poke_no_second", qa.size(), 32'd0);
        chk("poke_idle", {31'd0, a_busy}, 32'd0);

        // Reset during bit 4 of a TX frame (and its looped-back RX frame).
        dc = a_done_cnt;
        a_start = 1'b1; a_data = 8'h00; a_div = 16'd9;
        @(posedge clock); #1; a_start = 1'b0;
        idle(44);
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        chk("abort_txd", {31'd0, a_txd}, 32'd1);
        chk("abort_busy", {31'd0, a_busy}, 32'd0);
        idle(150);
        chk("abort_no_done", a_done_cnt, dc);
        chk("abort_no_dv", qa.size(), 32'd0);
        tx_frame(1'b0, 8'h5A, 9, 0);
        idle(20);
        rx_expect(1'b0, "after_abort", 8'h5A, 1'b0, 1'b0);

        // 7 data bits, odd parity, 2 stop bits, baud_div=3.
        tx_frame(1'b1, 8'h55, 3, 0);
        idle(30);
        rx_expect(1'b1, "b_55", 8'h55, 1'b0, 1'b0);

        // Random loopback frames, some chained, divisor varying per frame.
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            exp_q.push_back(d);
            tx_frame(1'b0, d, int'($urandom_range(3, 8)), 0);
            if ($urandom_range(0, 1) == 0) idle(int'($urandom_range(1, 20)));
        end
        idle(40);
        foreach (exp_q[i]) rx_expect(1'b0, "rand_lb", exp_q[i], 1'b0, 1'b0);
        chk("rand_lb_extra", qa.size(), 32'd0);

        // Random injected frames with random parity and stop bits.
        for (int i = 0; i < 8; i++) begin
            d  = 8'($urandom);
            pb = 1'($urandom);
            sb = 1'($urandom);
            dv = int'($urandom_range(3, 8));
            rx_drive(d, pb, sb, dv);
            rx_expect(1'b0, "rand_rx", d, pb != 1'((ones(d, 8)) % 2), ~sb);
        end

        // Random frames on the second parameter set.
        for (int i = 0; i < 4; i++) begin
            d = {1'b0, 7'($urandom)};
            tx_frame(1'b1, d, int'($urandom_range(3, 6)), 0);
            idle(30);
            rx_expect(1'b1, "rand_b", d, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
